// File: rtl/sequence_generator.sv
// ---------------------------------------------------------------------------
// sequence_generator
//   Serialises a captured bit pattern MSB-first (within 'length'), repeated
//   max(repeat_count,1) times with gap_len zero bits between repetitions,
//   followed by a one-cycle done pulse.
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   start         in   transmit request, sampled only in IDLE
//   abort         in   synchronous cancel while sending or in a gap
//   pattern       in   [PAT_W-1:0] bits to send
//   length        in   [LEN_W-1:0] bits per repetition (0 = ignore start,
//                      values above PAT_W are clamped)
//   repeat_count  in   [3:0] repetitions, 0 treated as 1
//   gap_len       in   [2:0] zero bits between repetitions
//   sequence_out  out  serial bit stream
//   bit_valid     out  sequence_out carries a pattern bit
//   busy          out  transmission in progress (through the done cycle)
//   done          out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module sequence_generator #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic [3:0]       repeat_count,
  input  logic [2:0]       gap_len,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  logic [1:0]       state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx;
  logic [3:0]       rep_left;
  logic [2:0]       gap_q;
  logic [2:0]       gap_cnt;

  logic [LEN_W-1:0] len_clamped;
  logic [PAT_W-1:0] bit_mask;

  assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
  assign bit_mask    = PAT_W'(1) << idx;

  // Moore outputs: decoded purely from registered state and datapath.
  assign bit_valid    = (state == SEND);
  assign sequence_out = (state == SEND) && |(pat_q & bit_mask);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      rep_left <= '0;
      gap_q    <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // start wins over abort here; abort has no meaning in IDLE.
          if (start && (length != '0)) begin
            pat_q    <= pattern;
            len_q    <= len_clamped;
            idx      <= len_clamped - LEN_W'(1);
            rep_left <= (repeat_count == '0) ? 4'd1 : repeat_count;
            gap_q    <= gap_len;
            gap_cnt  <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            state <= IDLE;
          end else if (idx == '0) begin
            // rep_left counts repetitions including the current one, so it
            // stops at 1 and never wraps.
            if (rep_left > 4'd1) begin
              rep_left <= rep_left - 4'd1;
              if (gap_q != '0) begin
                gap_cnt <= gap_q;
                state   <= GAP;
              end else begin
                idx <= len_q - LEN_W'(1);
              end
            end else begin
              state <= DONE;
            end
          end else begin
            idx <= idx - LEN_W'(1);
          end
        end
        GAP: begin
          if (abort) begin
            state <= IDLE;
          end else if (gap_cnt <= 3'd1) begin
            gap_cnt <= '0;
            idx     <= len_q - LEN_W'(1);
            state   <= SEND;
          end else begin
            gap_cnt <= gap_cnt - 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// ---------------------------------------------------------------------------
// tb_sequence_generator
//   Directed and randomized transactions against a list-based reference:
//   each accepted start expands into the expected per-cycle output stream
//   {sequence_out, bit_valid, busy, done}, truncated on abort or reset.
// ---------------------------------------------------------------------------
module tb_sequence_generator;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;

  logic             clock;
  logic             reset;
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] length;
  logic [3:0]       repeat_count;
  logic [2:0]       gap_len;
  logic             sequence_out;
  logic             bit_valid;
  logic             busy;
  logic             done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [3:0] exp_q[$];

  sequence_generator #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .pattern      (pattern),
    .length       (length),
    .repeat_count (repeat_count),
    .gap_len      (gap_len),
    .sequence_out (sequence_out),
    .bit_valid    (bit_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] observed,
                       input logic [3:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got {seq,valid,busy,done}=%b expected %b at %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic logic [3:0] outs();
    return {sequence_out, bit_valid, busy, done};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic scramble_inputs();
    start        = 1'($urandom);
    pattern      = PAT_W'($urandom);
    length       = LEN_W'($urandom);
    repeat_count = 4'($urandom);
    gap_len      = 3'($urandom);
  endtask

  // abort_k: first cycle (1-based, after accept) expected to be forced idle
  //          by an abort sampled at the preceding edge; 0 = no abort.
  // reset_k: cycle in which reset is pulsed asynchronously; 0 = none.
  task automatic run_txn(input logic [PAT_W-1:0] pat, input int len,
                         input int rep, input int gap,
                         input int abort_k, input int reset_k);
    int L;
    int R;
    int n;
    bit truncated;
    L = (len > PAT_W) ? PAT_W : len;
    R = (rep == 0) ? 1 : rep;
    exp_q.delete();
    truncated = 1'b0;

    pattern      = pat;
    length       = LEN_W'(len);
    repeat_count = 4'(rep);
    gap_len      = 3'(gap);
    start        = 1'b1;
    abort        = 1'($urandom);

    if (L == 0) begin
      for (int c = 0; c < 3; c++) begin
        step();
        check("len0_idle", outs(), 4'b0000);
      end
      start = 1'b0;
      abort = 1'b0;
      return;
    end

    for (int r = 0; r < R; r++) begin
      for (int b = L - 1; b >= 0; b--) exp_q.push_back({pat[b], 3'b110});
      if (r < R - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
    n = exp_q.size();

    step();
    for (int c = 1; c <= n; c++) begin
      if (abort_k != 0 && c == abort_k) begin
        check($sformatf("abort_c%0d", c), outs(), 4'b0000);
        truncated = 1'b1;
        break;
      end
      check($sformatf("stream_c%0d", c), outs(), exp_q[c-1]);
      if (reset_k == c) begin
        #2 reset = 1'b1;
        #1 check($sformatf("reset_c%0d", c), outs(), 4'b0000);
        #1 reset = 1'b0;
        truncated = 1'b1;
        break;
      end
      scramble_inputs();
      abort = (abort_k != 0 && c + 1 == abort_k);
      step();
    end
    if (!truncated) check("post_done_idle", outs(), 4'b0000);
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    pattern      = '0;
    length       = '0;
    repeat_count = '0;
    gap_len      = '0;
    #3 check("reset_state", outs(), 4'b0000);
    step();
    check("reset_held", outs(), 4'b0000);
    #2 reset = 1'b0;
    step();
    check("idle_after_reset", outs(), 4'b0000);

    run_txn(8'b0000_1011, 4, 1, 0, 0, 0);
    run_txn(8'b0000_1011, 4, 2, 0, 0, 0);
    run_txn(8'b0000_1011, 4, 2, 2, 0, 0);
    run_txn(8'b0000_1011, 0, 1, 0, 0, 0);
    run_txn(8'hA5, 12, 1, 0, 0, 0);
    run_txn(8'b0000_1011, 4, 1, 0, 3, 0);
    run_txn(8'b0000_1011, 4, 1, 0, 0, 0);
    run_txn(8'b0000_1011, 4, 2, 2, 0, 5);
    run_txn(8'b0000_1011, 4, 1, 0, 0, 0);
    run_txn(8'h81, 8, 0, 7, 0, 0);
    run_txn(8'h01, 1, 15, 0, 0, 0);
    run_txn(8'hFF, 8, 3, 1, 12, 0);

    for (int t = 0; t < 200; t++) begin
      int len;
      int rep;
      int gap;
      int L;
      int n;
      int ak;
      int rk;
      len = $urandom_range(0, 15);
      rep = $urandom_range(0, 15);
      gap = $urandom_range(0, 7);
      L   = (len > PAT_W) ? PAT_W : len;
      n   = L * ((rep == 0) ? 1 : rep) + gap * (((rep == 0) ? 1 : rep) - 1) + 1;
      ak  = 0;
      rk  = 0;
      case ($urandom_range(0, 5))
        0: ak = (n >= 2) ? $urandom_range(2, n) : 0;
        1: rk = $urandom_range(1, n);
        default: ;
      endcase
      run_txn(PAT_W'($urandom), len, rep, gap, ak, rk);
      if ($urandom_range(0, 1) == 1) begin
        step();
        check("idle_between", outs(), 4'b0000);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
